// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divider request/response bundle.
//   div_sign     1 = signed (DIV), 0 = unsigned (DIVU), sampled at start
//   div_start_i  request, held by the pipeline until ready_o is seen
//   div_annul_i  abort current or pending operation
//   div_op1      dividend, sampled at start
//   div_op2      divisor, sampled at start
//   result_o     {remainder, quotient}, registered
//   ready_o      result valid, registered
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 div_sign;
  logic                 div_start_i;
  logic                 div_annul_i;
  logic [WIDTH-1:0]     div_op1;
  logic [WIDTH-1:0]     div_op2;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output div_sign, div_start_i, div_annul_i, div_op1, div_op2,
    input  result_o, ready_o
  );

  modport slave (
    input  div_sign, div_start_i, div_annul_i, div_op1, div_op2,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per clock.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  div_unit_if slave: operands/start/annul in, {rem, quo}/ready out
// Latency is WIDTH cycles from the accepting edge to ready_o; a zero
// divisor completes in one cycle with an all-zero result.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t               state_q;
  logic [2*WIDTH:0]     acc_q;     // {partial remainder (WIDTH+1), quotient (WIDTH)}
  logic [2*WIDTH:0]     acc_d;
  logic [WIDTH-1:0]     dvs_q;
  logic                 qneg_q;
  logic                 rneg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic [WIDTH-1:0]     abs1;
  logic [WIDTH-1:0]     abs2;
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    abs1 = (bus.div_sign && bus.div_op1[WIDTH-1]) ? -bus.div_op1 : bus.div_op1;
    abs2 = (bus.div_sign && bus.div_op2[WIDTH-1]) ? -bus.div_op2 : bus.div_op2;
  end

  // One restoring step: shift, trial-subtract, keep on non-negative.
  always_comb begin
    shifted = {acc_q[2*WIDTH-1:0], 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      acc_d = shifted;
    end else begin
      acc_d = {trial, shifted[WIDTH-1:1], 1'b1};
    end
    quo_fix = qneg_q ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
    rem_fix = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.div_start_i && !bus.div_annul_i) begin
            if (bus.div_op2 == '0) begin
              state_q <= BYZERO;
            end else begin
              // Remainder half starts cleared; the dividend magnitude sits
              // in the quotient half and is shifted out as quotient bits enter.
              acc_q   <= {{(WIDTH+1){1'b0}}, abs1};
              dvs_q   <= abs2;
              qneg_q  <= bus.div_sign & (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
              rneg_q  <= bus.div_sign & bus.div_op1[WIDTH-1];
              cnt_q   <= '0;
              state_q <= ON;
            end
          end
        end
        BYZERO: begin
          if (bus.div_annul_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        ON: begin
          if (bus.div_annul_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= 1'b1;
              state_q  <= END;
            end
          end
        end
        END: begin
          if (!bus.div_start_i) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero,
  // remainder takes the dividend's sign, matching DIV/DIVU semantics.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with DUT idle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [63:0] exp;
    int n;
    exp = ref_div(a, b, s);
    n = 0;
    bus.div_op1 = a;
    bus.div_op2 = b;
    bus.div_sign = s;
    bus.div_start_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (i == 0) begin
        bus.div_op1 = $urandom;
        bus.div_op2 = $urandom;
        bus.div_sign = 1'($urandom_range(0, 1));
      end
      if (bus.ready_o) break;
    end
    check({tag, "_latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
    check({tag, "_result"}, bus.result_o, exp);
    @(posedge clk); #1;
    check({tag, "_ready_held"}, 64'(bus.ready_o), 64'd1);
    bus.div_start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_result_kept"}, bus.result_o, exp);
  endtask

  initial begin
    logic [63:0] prev;
    bit          saw_ready;
    rst = 1'b1;
    bus.div_sign = 1'b0;
    bus.div_start_i = 1'b0;
    bus.div_annul_i = 1'b0;
    bus.div_op1 = '0;
    bus.div_op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7_const", bus.result_o, {32'd2, 32'd14});
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "s_m7_2");
    check("s_m7_2_const", bus.result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div(32'hFFFFFFF9, 32'd2, 1'b0, "u_m7_2");
    check("u_m7_2_const", bus.result_o, {32'd1, 32'h7FFFFFFC});
    run_div(32'd5, 32'd9, 1'b0, "u5_9");
    run_div(32'h12345678, 32'd0, 1'b1, "byzero");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "s_ovf");
    check("s_ovf_const", bus.result_o, {32'd0, 32'h80000000});

    // Annul after step 10.
    prev = bus.result_o;
    bus.div_op1 = 32'hDEADBEEF;
    bus.div_op2 = 32'h1234;
    bus.div_sign = 1'b0;
    bus.div_start_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    bus.div_start_i = 1'b0;
    bus.div_annul_i = 1'b1;
    @(posedge clk); #1;
    bus.div_annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready_o) saw_ready = 1'b1; end
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    check("annul_result_kept", bus.result_o, prev);
    run_div(32'd9, 32'd3, 1'b0, "after_annul");
    check("after_annul_const", bus.result_o, {32'd0, 32'd3});

    // Start with annul in IDLE is never accepted.
    bus.div_op1 = 32'd50;
    bus.div_op2 = 32'd5;
    bus.div_start_i = 1'b1;
    bus.div_annul_i = 1'b1;
    saw_ready = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready_o) saw_ready = 1'b1; end
    check("idle_annul_no_ready", 64'(saw_ready), 64'd0);
    check("idle_annul_result", bus.result_o, {32'd0, 32'd3});
    bus.div_start_i = 1'b0;
    bus.div_annul_i = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a division.
    bus.div_op1 = 32'h11111111;
    bus.div_op2 = 32'd3;
    bus.div_start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_result", bus.result_o, 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    bus.div_start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, "after_rst");
    check("after_rst_const", bus.result_o, {32'hF, 32'h0FFFFFFF});

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(1, 17));
        1: b = -32'($urandom_range(1, 17));
        2: b = 32'd0;
        3: a = 32'h80000000;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_div(a, b, s, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
